// File: rtl/pes_ram_bist_pkg.sv
// Shared sizes, limits and FSM encoding for the dual-port RAM march BIST.
package pes_ram_bist_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DEPTH   = 64;
  localparam int unsigned ERR_W   = 7;
  localparam int unsigned ERR_MAX = 127;

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0,
    StD0,
    StW1,
    StR1,
    StD1,
    StDone
  } bist_state_e;

endpackage

// File: rtl/pes_ram_bist_ctrl_if.sv
// Both ports of the dual-port RAM under test; the controller is the master.
interface pes_ram_bist_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 6
) ();

  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_data_a;
  logic              ram_we_a;
  logic [DATA_W-1:0] ram_q_a;
  logic [ADDR_W-1:0] ram_addr_b;
  logic [DATA_W-1:0] ram_data_b;
  logic              ram_we_b;
  logic [DATA_W-1:0] ram_q_b;

  modport master (
    output ram_addr_a, ram_data_a, ram_we_a,
    input  ram_q_a,
    output ram_addr_b, ram_data_b, ram_we_b,
    input  ram_q_b
  );

  modport slave (
    input  ram_addr_a, ram_data_a, ram_we_a,
    output ram_q_a,
    input  ram_addr_b, ram_data_b, ram_we_b,
    output ram_q_b
  );

endinterface

// File: rtl/pes_ram_bist_cmp.sv
// Read-data checker: aligns expected data/address with the 1-cycle RAM read latency,
// counts mismatches (saturating) and records the first failing address and data.
module pes_ram_bist_cmp
  import pes_ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = pes_ram_bist_pkg::DATA_W,
  parameter int unsigned ADDR_W = pes_ram_bist_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_rd_en,
  input  logic              i_rd_port_a,
  input  logic [DATA_W-1:0] i_exp,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_q_a,
  input  logic [DATA_W-1:0] i_q_b,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [ADDR_W-1:0] o_fail_addr,
  output logic [DATA_W-1:0] o_fail_data
);

  logic              r_vld;
  logic              r_sel_a;
  logic [DATA_W-1:0] r_exp;
  logic [ADDR_W-1:0] r_addr;
  logic [ERR_W-1:0]  r_err;
  logic [ADDR_W-1:0] r_fail_addr;
  logic [DATA_W-1:0] r_fail_data;

  logic [DATA_W-1:0] w_q;
  logic              w_mis;

  always_comb begin
    w_q   = r_sel_a ? i_q_a : i_q_b;
    w_mis = r_vld && (w_q != r_exp);
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_vld       <= 1'b0;
      r_sel_a     <= 1'b0;
      r_exp       <= '0;
      r_addr      <= '0;
      r_err       <= '0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
    end else begin
      r_vld   <= i_rd_en;
      r_sel_a <= i_rd_port_a;
      r_exp   <= i_exp;
      r_addr  <= i_addr;
      if (w_mis) begin
        if (r_err != ERR_W'(ERR_MAX)) begin
          r_err <= r_err + ERR_W'(1);
        end
        // The count never wraps, so zero means no mismatch has been captured yet.
        if (r_err == '0) begin
          r_fail_addr <= r_addr;
          r_fail_data <= w_q;
        end
      end
    end
  end

  assign o_err_count = r_err;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_data = r_fail_data;

endmodule

// File: rtl/pes_ram_bist_ctrl.sv
// March BIST for a dual-port RAM: write P up / read P up via A,B, then write ~P down /
// read ~P down via B,A, with a drain cycle after each read phase.
module pes_ram_bist_ctrl
  import pes_ram_bist_pkg::*;
#(
  parameter int unsigned DATA_W = pes_ram_bist_pkg::DATA_W,
  parameter int unsigned ADDR_W = pes_ram_bist_pkg::ADDR_W,
  parameter int unsigned DEPTH  = pes_ram_bist_pkg::DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATA_W-1:0]    pattern,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    fail_addr,
  output logic [DATA_W-1:0]    fail_data,
  pes_ram_bist_ctrl_if.master  ram
);

  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(DEPTH - 1);

  bist_state_e       r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_pat;

  bist_state_e       w_state_d;
  logic [ADDR_W-1:0] w_addr_d;
  logic [DATA_W-1:0] w_pat_d;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_rd_port_a;
  logic [DATA_W-1:0] w_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_pat   <= '0;
    end else begin
      r_state <= w_state_d;
      r_addr  <= w_addr_d;
      r_pat   <= w_pat_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_addr_d  = r_addr;
    w_pat_d   = r_pat;
    w_accept  = start && ((r_state == StIdle) || (r_state == StDone));
    unique case (r_state)
      StIdle, StDone: begin
        if (w_accept) begin
          w_state_d = StW0;
          w_addr_d  = '0;
          w_pat_d   = pattern;
        end
      end
      StW0: begin
        if (r_addr == AddrLast) begin
          w_state_d = StR0;
          w_addr_d  = '0;
        end else begin
          w_addr_d = r_addr + ADDR_W'(1);
        end
      end
      StR0: begin
        if (r_addr == AddrLast) w_state_d = StD0;
        else                    w_addr_d  = r_addr + ADDR_W'(1);
      end
      StD0: begin
        w_state_d = StW1;
        w_addr_d  = AddrLast;
      end
      StW1: begin
        if (r_addr == '0) begin
          w_state_d = StR1;
          w_addr_d  = AddrLast;
        end else begin
          w_addr_d = r_addr - ADDR_W'(1);
        end
      end
      StR1: begin
        if (r_addr == '0) w_state_d = StD1;
        else              w_addr_d  = r_addr - ADDR_W'(1);
      end
      StD1:    w_state_d = StDone;
      default: w_state_d = StIdle;
    endcase
  end

  // Ports not used by the current phase are parked at zero.
  always_comb begin
    ram.ram_addr_a = ((r_state == StW0) || (r_state == StR1)) ? r_addr : '0;
    ram.ram_data_a = (r_state == StW0) ? r_pat : '0;
    ram.ram_we_a   = (r_state == StW0);
    ram.ram_addr_b = ((r_state == StR0) || (r_state == StW1)) ? r_addr : '0;
    ram.ram_data_b = (r_state == StW1) ? ~r_pat : '0;
    ram.ram_we_b   = (r_state == StW1);
  end

  always_comb begin
    w_rd_en     = (r_state == StR0) || (r_state == StR1);
    w_rd_port_a = (r_state == StR1);
    w_exp       = (r_state == StR1) ? ~r_pat : r_pat;
    busy        = (r_state != StIdle) && (r_state != StDone);
    done        = (r_state == StDone);
    pass        = done && (err_count == '0);
  end

  pes_ram_bist_cmp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_cmp (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (w_accept),
    .i_rd_en     (w_rd_en),
    .i_rd_port_a (w_rd_port_a),
    .i_exp       (w_exp),
    .i_addr      (r_addr),
    .i_q_a       (ram.ram_q_a),
    .i_q_b       (ram.ram_q_b),
    .o_err_count (err_count),
    .o_fail_addr (fail_addr),
    .o_fail_data (fail_data)
  );

endmodule

// File: tb/tb_pes_ram_bist_ctrl.sv
// Directed bench: behavioural 64x8 dual-port RAM with stuck-bit and forced-zero faults.
module tb_pes_ram_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pattern;
  logic       busy, done, pass;
  logic [6:0] err_count;
  logic [5:0] fail_addr;
  logic [7:0] fail_data;

  int total = 0;
  int bad   = 0;

  logic       f_stuck = 1'b0;
  logic       f_zero  = 1'b0;
  logic [7:0] mem [64];
  logic [7:0] r_qa, r_qb;

  pes_ram_bist_ctrl_if #(.DATA_W(8), .ADDR_W(6)) ram_if ();

  pes_ram_bist_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr),
    .fail_data (fail_data),
    .ram       (ram_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_if.ram_we_a) mem[ram_if.ram_addr_a] <= ram_if.ram_data_a;
    if (ram_if.ram_we_b) mem[ram_if.ram_addr_b] <= ram_if.ram_data_b;
    r_qa <= mem[ram_if.ram_addr_a] & ((f_stuck && ram_if.ram_addr_a == 6'h2A) ? 8'hFE : 8'hFF);
    r_qb <= mem[ram_if.ram_addr_b] & ((f_stuck && ram_if.ram_addr_b == 6'h2A) ? 8'hFE : 8'hFF);
  end

  assign ram_if.ram_q_a = f_zero ? 8'h00 : r_qa;
  assign ram_if.ram_q_b = f_zero ? 8'h00 : r_qb;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start at edge 0; DONE must appear exactly at edge 258.
  task automatic run_bist(input logic [7:0] p, input int restart_at, input string tag);
    int n_busy;
    int n_done;
    logic [7:0] np;
    np      = ~p;
    pattern = p;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    pattern = np;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_err_clr"}, err_count, 0);
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_we_a_w0"}, ram_if.ram_we_a, 1);
    chk({tag, "_data_a_w0"}, ram_if.ram_data_a, p);
    n_busy = 0;
    n_done = 0;
    for (int i = 1; i <= 257; i++) begin
      if (i == restart_at) begin
        start   = 1'b1;
        pattern = 8'h00;
      end
      tick();
      start = 1'b0;
      if (busy) n_busy++;
      if (done) n_done++;
      if (i == 129) begin
        chk({tag, "_we_b_w1"}, ram_if.ram_we_b, 1);
        chk({tag, "_we_a_w1"}, ram_if.ram_we_a, 0);
        chk({tag, "_addr_b_w1"}, ram_if.ram_addr_b, 6'h3F);
        chk({tag, "_data_b_w1"}, ram_if.ram_data_b, np);
      end
    end
    tick();
    chk({tag, "_busy_cycles"}, n_busy, 257);
    chk({tag, "_early_done"}, n_done, 0);
    chk({tag, "_done_e258"}, done, 1);
    chk({tag, "_busy_e258"}, busy, 0);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    pattern = 8'h00;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_fail_data", fail_data, 0);
    chk("rst_we_a", ram_if.ram_we_a, 0);
    chk("rst_we_b", ram_if.ram_we_b, 0);
    chk("rst_addr_a", ram_if.ram_addr_a, 0);
    chk("rst_data_b", ram_if.ram_data_b, 0);

    // rst wins over start in the same cycle
    start = 1'b1;
    pattern = 8'hA5;
    tick();
    start = 1'b0;
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0;
    tick();

    run_bist(8'hA5, 0, "clean");
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);
    chk("clean_fail_addr", fail_addr, 0);

    run_bist(8'hA5, 100, "restart");
    chk("restart_pass", pass, 1);
    chk("restart_err", err_count, 0);
    tick();
    tick();
    chk("restart_done_hold", done, 1);
    chk("restart_pass_hold", pass, 1);

    f_zero = 1'b1;
    run_bist(8'h0F, 0, "zero");
    f_zero = 1'b0;
    chk("zero_err_sat", err_count, 127);
    chk("zero_fail_addr", fail_addr, 6'h00);
    chk("zero_fail_data", fail_data, 8'h00);
    chk("zero_pass", pass, 0);

    f_stuck = 1'b1;
    run_bist(8'h55, 0, "stuck");
    f_stuck = 1'b0;
    chk("stuck_err", err_count, 1);
    chk("stuck_fail_addr", fail_addr, 6'h2A);
    chk("stuck_fail_data", fail_data, 8'h54);
    chk("stuck_pass", pass, 0);

    // Rerun from DONE: results clear on acceptance (checked inside run_bist)
    run_bist(8'h96, 0, "rerun");
    chk("rerun_pass", pass, 1);
    chk("rerun_fail_addr", fail_addr, 0);
    chk("rerun_fail_data", fail_data, 0);

    // Abort mid-test
    pattern = 8'h3C;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    repeat (69) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_we_a", ram_if.ram_we_a, 0);
    chk("abort_we_b", ram_if.ram_we_b, 0);
    chk("abort_done", done, 0);
    chk("abort_err", err_count, 0);
    rst = 1'b0;
    tick();
    run_bist(8'h3C, 0, "after_abort");
    chk("after_abort_pass", pass, 1);
    chk("after_abort_err", err_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pes_ram_bist_ctrl.md
PES_RAM_BIST_CTRL -- requirements
Module: pes_ram_bist_ctrl

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-002 SHALL have ports: start input 1, test request; pattern input 8, background data, sampled when start is accepted.
REQ-003 SHALL have ports: busy output 1; done output 1; pass output 1; err_count output 7, saturating mismatch count; fail_addr output 6 and fail_data output 8, first mismatch.
REQ-004 SHALL have RAM port A: ram_addr_a output 6; ram_data_a output 8; ram_we_a output 1; ram_q_a input 8.
REQ-005 SHALL have RAM port B: ram_addr_b, ram_data_b, ram_we_b, ram_q_b with the same widths and directions as port A.
REQ-006 SHALL use parameters DATA_W default 8 (word width), ADDR_W default 6 (address width) and DEPTH default 64 (words).

Function
REQ-007 SHALL treat the target RAM as 64x8 dual-port: a write commits at the clock edge; with we low, q becomes valid one cycle after the address is presented.
REQ-008 SHALL implement states IDLE, W0, R0, D0, W1, R1, D1, DONE.
REQ-009 SHALL accept start only in IDLE or DONE: clear err_count, fail_*, done and pass, latch pattern as P, and enter W0 with addr counter 0.
REQ-010 W0 SHALL write P via port A to addresses 0..63 ascending, one per cycle, then enter R0.
REQ-011 R0 SHALL read via port B at addresses 0..63 ascending and compare each ram_q_b with P one cycle later; D0 is a 1-cycle drain for the final compare.
REQ-012 W1 SHALL write ~P via port B to addresses 63..0 descending; R1 SHALL read via port A 63..0 descending, compare against ~P; D1 drains the last compare.
REQ-013 Address counter SHALL be 6-bit; phase ends on the terminal address (63 ascending, 0 descending), and the counter is reloaded at each phase entry with no wrap-around.
REQ-014 ram_we_a SHALL be 1 only in W0, and ram_we_b only in W1; the idle port SHALL hold addr 0, data 0, we 0.
REQ-015 busy SHALL be 1 in W0..D1; total test length is exactly 258 cycles, and DONE is entered at the 258th edge after the start-sampling edge.
REQ-016 Each mismatch SHALL increment err_count, saturating at 127.
REQ-017 On the first mismatch only, the block SHALL capture fail_addr (the address issued) and fail_data (the value read).
REQ-018 In DONE, done SHALL be 1, and pass SHALL equal (err_count==0); both SHALL hold until start or rst.
REQ-019 start while busy SHALL be ignored.

Reset
REQ-020 rst SHALL force, at the next edge: state IDLE; busy, done, pass 0; err_count 0; fail_addr 0; fail_data 0; all RAM outputs 0.
REQ-021 rst mid-test SHALL abort with no further RAM writes; RAM contents are then undefined and SHALL NOT be restored.
REQ-022 rst SHALL take priority over start in the same cycle.

Structure
REQ-023 Package pes_ram_bist_pkg SHALL hold DATA_W, ADDR_W, DEPTH, the state encoding and ERR_MAX=127.
REQ-024 Sub-module pes_ram_bist_cmp SHALL hold the delayed expected/valid/address pipeline, the mismatch compare, the saturating counter and first-fail capture.
REQ-025 FSM and address counter SHALL reside in the top level.

Verification (bench uses a behavioural 64x8 dual-port RAM with fault injection)
REQ-026 Fault-free, P=8'hA5, start at edge 0 -> busy 258 cycles; done=1 at edge 258; pass=1; err_count=0.
REQ-027 Bit0 stuck-at-0 at addr 0x2A, P=8'h55 -> err_count=1, fail_addr=0x2A, fail_data=8'h54, pass=0.
REQ-028 Both q ports forced 8'h00, P=8'h0F -> 128 mismatches; err_count saturates at 127; fail_addr=0x00; fail_data=0x00.
REQ-029 Second start pulse at cycle 100 -> ignored; done still at edge 258, and results are identical to REQ-026.
REQ-030 rst at cycle 70 -> next edge: busy=0, ram_we_a=ram_we_b=0, done=0; a subsequent start (P=8'h3C) passes in 258 cycles.
REQ-031 start issued in DONE after REQ-027 -> results cleared on acceptance; a fault-free rerun gives pass=1.
